bp_cce_resource_arbiter: RTL
============================

// Module: bp_cce_resource_arbiter
// PURPOSE
//  N-way arbiter granting one CCE shared resource port (directory, pending or spec bits) per transfer.
//  Replaces the fixed two-input message-over-microcode mux.
//  Adds round-robin or fixed priority, starvation escalation, valid/ready handshake and a registered output stage.
//  Sits between the requesters (microcode, message unit, ...) and one resource; instantiate once per resource.
// PARAMETERS
//  num_req_p        2    number of requesters; requester 0 is the highest fixed priority
//  data_width_p     64   packed request payload width (addr, bypass, cmd, state, ...)
//  fixed_prio_p     0    0 = round-robin, 1 = fixed priority (lowest index wins)
//  starve_limit_p   8    lost arbitrations before a requester is escalated; must be >= 1
// PORTS
//  clk_i          in   1                   clock
//  reset_n_i      in   1                   asynchronous reset, active low
//  req_v_i        in   num_req_p           per-requester request valid
//  req_data_i     in   num_req_p*data_w    per-requester payload; slice i belongs to requester i
//  req_lock_i     in   num_req_p           hold grant after this beat (only with BP_CCE_ARB_LOCK_EN)
//  req_ready_o    out  num_req_p           one-hot; beat of requester i accepted this cycle
//  v_o            out  1                   output payload valid
//  data_o         out  data_width_p        granted payload (registered)
//  grant_id_o     out  clog2(num_req_p)    index of the requester that owns data_o
//  ready_i        in   1                   resource consumes data_o when v_o & ready_i
//  starve_o       out  1                   some requester is currently escalated (debug/perf)
// BEHAVIOUR
//  Reset (async assert, sync release): v_o=0, data_o=0, grant_id_o=0, starve_o=0.
//    Also clears the rr pointer, all starvation counters and the lock.
//  Output stage is a single register: accept = ~v_o | ready_i.
//    On accept with any req_v_i, load the winner, set v_o=1; otherwise v_o <= v_o & ~ready_i.
//  req_ready_o[i] = accept & grant[i]; combinational, at most one bit set; 0 when no req_v_i.
//  Latency: request accepted in cycle t appears on data_o in t+1. Full throughput with ready_i held 1.
//  Winner selection, in priority order:
//    (1) lock owner, if a lock is active;
//    (2) lowest-index escalated requester, if any is escalated;
//    (3) fixed_prio_p=1: lowest-index valid requester;
//        fixed_prio_p=0: first valid requester at or after rr_ptr, wrapping num_req_p-1 -> 0.
//  rr_ptr <= (winner+1) mod num_req_p on each accepted beat; it does not change when no beat is accepted.
//  Starvation counter per requester, width clog2(starve_limit_p+1):
//    +1 on each accepted beat where req_v_i[i]=1 and i lost; saturates at starve_limit_p.
//    Cleared when i wins, or when req_v_i[i]=0.
//    Requester is escalated when its counter == starve_limit_p.
//  starve_o = OR of the escalated flags.
//  Backpressure: when accept=0, no counters, rr_ptr or lock change. Requesters must hold req_v_i and data until ready.
//  Single requester, or num_req_p=1: granted every accepting cycle; grant_id_o=0.
//  Reset mid-transfer: the in-flight data_o is dropped and no replay occurs; requesters re-present.
// CONFIGURATION
//  `BP_CCE_ARB_LOCK_EN defined:
//    An accepted beat with req_lock_i[winner]=1 sets the lock to that requester.
//    While the lock is held, only the lock owner can win. Others see req_ready_o=0 and their counters freeze.
//    Lock clears on the owner's accepted beat with req_lock_i=0.
//    Lock still holds if the owner drops req_v_i.
//  Not defined: req_lock_i is ignored and the lock state is absent.
// STRUCTURE
//  bp_cce_pkg: typedef bp_cce_arb_mode_e {e_arb_rr, e_arb_fixed}; the starve-limit default constant.
//  Sub-module bp_cce_arb_starve_ctr: one saturating counter plus escalated flag; generated num_req_p times.
//  Top: winner select, rr pointer, lock register, output register.
// TESTING
//  rr, N=3, all req_v_i=1, ready_i=1 -> grant_id_o sequence 0,1,2,0,1,2 starting the cycle after reset release.
//  fixed, N=2, both valid, starve_limit_p=4 -> 0,0,0,0 then 1 (req 1 escalated, starve_o=1), then 0 again.
//  ready_i=0 for 5 cycles with v_o=1 -> data_o, grant_id_o and all req_ready_o stable; no counter movement.
//  LOCK_EN: req 1 beats with lock=1,1,0 while req 0 valid -> grants 1,1,1, then 0.
//  reset_n_i low mid-stream with v_o=1 -> v_o=0 asynchronously; first grant after release is req 0 (rr_ptr=0).
//  Only req 2 valid, N=4 rr, rr_ptr=3 -> wrap; grant_id_o=2 next cycle; rr_ptr becomes 3.

Source files
------------

// File: rtl/bp_cce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_cce_pkg
// Purpose  : Shared types and constants for the CCE resource arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bp_cce_pkg;

    typedef enum logic {
        e_arb_rr    = 1'b0,
        e_arb_fixed = 1'b1
    } bp_cce_arb_mode_e;

    localparam int c_starve_limit_default = 8;

    // clog2 that never yields a zero-width vector
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_cce_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bp_cce_arb_starve_ctr
// Purpose  : Saturating lost-arbitration counter with escalated flag.
// Revision : 1.0 - initial release
// ============================================================================
module bp_cce_arb_starve_ctr
    import bp_cce_pkg::*;
#(
    parameter int starve_limit_p = c_starve_limit_default
)(
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en_i,
    input  logic req_v_i,
    input  logic win_i,
    output logic escalated_o
);

    localparam int c_cnt_w = safe_clog2(starve_limit_p + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(starve_limit_p);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            if (!req_v_i || win_i) begin
                r_cnt <= '0;
            end else if (r_cnt != c_limit) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign escalated_o = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/bp_cce_resource_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_cce_resource_arbiter
// Purpose  : N-way round-robin/fixed arbiter with starvation escalation and a
//            registered output stage. Optional grant lock: BP_CCE_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bp_cce_resource_arbiter
    import bp_cce_pkg::*;
#(
    parameter  int num_req_p      = 2,
    parameter  int data_width_p   = 64,
    parameter  int fixed_prio_p   = 0,
    parameter  int starve_limit_p = c_starve_limit_default,
    localparam int id_width_lp    = safe_clog2(num_req_p)
)(
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]              req_lock_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic                              v_o,
    output logic [data_width_p-1:0]           data_o,
    output logic [id_width_lp-1:0]            grant_id_o,
    input  logic                              ready_i,
    output logic                              starve_o
);

    localparam bp_cce_arb_mode_e c_mode = (fixed_prio_p != 0) ? e_arb_fixed : e_arb_rr;

    logic                    w_accept;
    logic                    w_fire;
    logic                    w_found;
    logic [id_width_lp-1:0]  w_winner;
    logic [id_width_lp-1:0]  w_rr_next;
    logic [num_req_p-1:0]    w_cand;
    logic [num_req_p-1:0]    w_grant;
    logic [num_req_p-1:0]    w_escalated;
    logic [num_req_p-1:0]    w_frozen;
    logic [num_req_p-1:0]    w_ctr_en;
    logic [data_width_p-1:0] w_win_data;
    logic [id_width_lp-1:0]  r_rr_ptr;

`ifdef BP_CCE_ARB_LOCK_EN
    logic                   r_lock_v;
    logic [id_width_lp-1:0] r_lock_id;

    // While locked only the owner is a candidate; everyone else is frozen
    always_comb begin
        w_cand   = req_v_i;
        w_frozen = '0;
        if (r_lock_v) begin
            w_cand            = '0;
            w_cand[r_lock_id] = req_v_i[r_lock_id];
            w_frozen          = '1;
            w_frozen[r_lock_id] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_lock_v  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_fire) begin
            r_lock_v  <= req_lock_i[w_winner];
            r_lock_id <= w_winner;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock_i;
    assign w_cand        = req_v_i;
    assign w_frozen      = '0;
`endif

    assign w_accept = ~v_o | ready_i;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!w_found && w_cand[i] && w_escalated[i]) begin
                w_found  = 1'b1;
                w_winner = id_width_lp'(i);
            end
        end
        if (!w_found) begin
            if (c_mode == e_arb_fixed) begin
                for (int i = 0; i < num_req_p; i++) begin
                    if (!w_found && w_cand[i]) begin
                        w_found  = 1'b1;
                        w_winner = id_width_lp'(i);
                    end
                end
            end else begin
                // Scan starting at the rr pointer, wrapping past the top index
                for (int k = 0; k < num_req_p; k++) begin
                    if (!w_found && w_cand[(int'(r_rr_ptr) + k) % num_req_p]) begin
                        w_found  = 1'b1;
                        w_winner = id_width_lp'((int'(r_rr_ptr) + k) % num_req_p);
                    end
                end
            end
        end
    end

    always_comb begin
        w_grant    = '0;
        w_win_data = '0;
        if (w_found) begin
            w_grant[w_winner] = 1'b1;
        end
        for (int i = 0; i < num_req_p; i++) begin
            if (w_grant[i]) begin
                w_win_data = req_data_i[i*data_width_p +: data_width_p];
            end
        end
    end

    assign w_fire      = w_accept & w_found;
    assign req_ready_o = w_accept ? w_grant : '0;
    assign w_rr_next   = id_width_lp'((int'(w_winner) + 1) % num_req_p);
    assign w_ctr_en    = w_fire ? ~w_frozen : '0;
    assign starve_o    = |w_escalated;

    for (genvar g = 0; g < num_req_p; g++) begin : g_starve
        bp_cce_arb_starve_ctr #(
            .starve_limit_p (starve_limit_p)
        ) u_ctr (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .en_i        (w_ctr_en[g]),
            .req_v_i     (req_v_i[g]),
            .win_i       (w_grant[g]),
            .escalated_o (w_escalated[g])
        );
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o        <= 1'b0;
            data_o     <= '0;
            grant_id_o <= '0;
            r_rr_ptr   <= '0;
        end else if (w_fire) begin
            v_o        <= 1'b1;
            data_o     <= w_win_data;
            grant_id_o <= w_winner;
            r_rr_ptr   <= w_rr_next;
        end else begin
            v_o        <= v_o & ~ready_i;
        end
    end

endmodule
`default_nettype wire
